axi_rd_ctrl: RTL and testbench

Read-side counterpart of the user-to-AXI write packer. On a user request it issues one fixed-length burst read descriptor (address, length) to the AXI master engine. It accepts the returned P_AXI_DATA_WIDTH-bit beats and unpacks each beat into P_USER_DATA_WIDTH-bit words, least-significant slice first. The read address walks a ring from base to final address, mirroring the write-side addressing so data written by the packer reads back in order.

---
 rtl/axi_rd_pkg.sv | 26 ++
 rtl/axi_rd_ctrl_if.sv | 35 +++
 rtl/axi_rd_unpack.sv | 71 +++++++
 rtl/axi_rd_ctrl.sv | 157 +++++++++++++++
 tb/tb_axi_rd_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and derived-constant helpers for the AXI read controller.
// Optional build macro used by the top: AXI_RD_LAST_CHECK_EN.
package axi_rd_pkg;

  localparam int P_RD_LENGTH_DEF       = 4096;
  localparam int P_USER_DATA_WIDTH_DEF = 16;
  localparam int P_AXI_DATA_WIDTH_DEF  = 128;
  localparam int P_AXI_ADDR_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } axi_rd_state_t;

  // User words packed into one AXI beat.
  function automatic int calc_width_cnt_max(input int axi_w, input int user_w);
    return axi_w / user_w;
  endfunction

  // AXI length field value (beats - 1) for one burst of rd_len bytes.
  function automatic int calc_burst_len(input int rd_len, input int axi_w);
    return rd_len / (axi_w / 8) - 1;
  endfunction

endpackage

// File: rtl/axi_rd_ctrl_if.sv
// User-side and AXI-engine-side signals of the read controller.
// Handshake: a beat transfers on a rising edge where i_a2u_valid && o_a2u_ready;
// o_a2u_ready never depends on i_a2u_valid. A descriptor is offered with
// o_a2u_en held high and stable until the cycle i_a2u_ack is sampled high.
interface axi_rd_ctrl_if #(
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_DATA_WIDTH  = 128,
  parameter int P_AXI_ADDR_WIDTH  = 32
);
  logic                         i_user_req;
  logic                         o_user_busy;
  logic [P_USER_DATA_WIDTH-1:0] o_user_data;
  logic                         o_user_valid;
  logic                         o_user_last;
  logic                         o_a2u_en;
  logic                         i_a2u_ack;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_a2u_addr;
  logic [7:0]                   o_a2u_length;
  logic [P_AXI_DATA_WIDTH-1:0]  i_a2u_data;
  logic                         i_a2u_valid;
  logic                         i_a2u_last;
  logic                         o_a2u_ready;

  modport slave (
    input  i_user_req, i_a2u_ack, i_a2u_data, i_a2u_valid, i_a2u_last,
    output o_user_busy, o_user_data, o_user_valid, o_user_last,
           o_a2u_en, o_a2u_addr, o_a2u_length, o_a2u_ready
  );

  modport master (
    output i_user_req, i_a2u_ack, i_a2u_data, i_a2u_valid, i_a2u_last,
    input  o_user_busy, o_user_data, o_user_valid, o_user_last,
           o_a2u_en, o_a2u_addr, o_a2u_length, o_a2u_ready
  );
endinterface

// File: rtl/axi_rd_unpack.sv
// Width converter: holds one AXI beat and emits it as user words, LS slice first.
// A new beat is taken when empty or while the last slice is going out.
module axi_rd_unpack
  import axi_rd_pkg::*;
#(
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_DATA_WIDTH  = 128
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [P_AXI_DATA_WIDTH-1:0]  i_data,
  input  logic                         i_valid,
  input  logic                         i_last_beat,
  output logic                         o_ready,
  output logic                         o_accept,
  output logic [P_USER_DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_last
);

  localparam int P_WIDTH_CNT_MAX = calc_width_cnt_max(P_AXI_DATA_WIDTH, P_USER_DATA_WIDTH);
  localparam int P_SLICE_W       = (P_WIDTH_CNT_MAX > 1) ? $clog2(P_WIDTH_CNT_MAX) : 1;
  localparam logic [P_SLICE_W-1:0] P_SLICE_LAST = P_SLICE_W'(P_WIDTH_CNT_MAX - 1);

  logic [P_AXI_DATA_WIDTH-1:0]  r_hold;
  logic                         r_hold_last;
  logic                         r_full;
  logic [P_SLICE_W-1:0]         r_slice;
  logic [P_USER_DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_last;
  logic                         w_slice_end;

  assign w_slice_end = r_full && (r_slice == P_SLICE_LAST);
  assign o_ready     = i_en && (!r_full || w_slice_end);
  assign o_accept    = o_ready && i_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_full      <= 1'b0;
      r_slice     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      if (o_accept) begin
        r_hold      <= i_data;
        r_hold_last <= i_last_beat;
        r_full      <= 1'b1;
        r_slice     <= '0;
      end else if (w_slice_end) begin
        r_full <= 1'b0;
      end else if (r_full) begin
        r_slice <= r_slice + 1'b1;
      end
      r_valid <= r_full;
      r_last  <= w_slice_end && r_hold_last;
      if (r_full) begin
        r_data <= r_hold[r_slice*P_USER_DATA_WIDTH +: P_USER_DATA_WIDTH];
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/axi_rd_ctrl.sv
// Burst read controller: issues fixed-length read descriptors walking an address
// ring and unpacks returned beats into user words. Macro AXI_RD_LAST_CHECK_EN
// enables the sticky i_a2u_last protocol check on o_err.
module axi_rd_ctrl
  import axi_rd_pkg::*;
#(
  parameter int P_RD_LENGTH       = P_RD_LENGTH_DEF,
  parameter int P_USER_DATA_WIDTH = P_USER_DATA_WIDTH_DEF,
  parameter int P_AXI_DATA_WIDTH  = P_AXI_DATA_WIDTH_DEF,
  parameter int P_AXI_ADDR_WIDTH  = P_AXI_ADDR_WIDTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ddr_init,
  input  logic [P_AXI_ADDR_WIDTH-1:0] i_user_baddr,
  input  logic [P_AXI_ADDR_WIDTH-1:0] i_user_faddr,
  axi_rd_ctrl_if.slave                bus,
  output logic                        o_err,
  output axi_rd_state_t               o_dbg_state
);

  localparam int         P_BURST_LEN = calc_burst_len(P_RD_LENGTH, P_AXI_DATA_WIDTH);
  localparam logic [7:0] P_LEN_B     = 8'(P_BURST_LEN);

  axi_rd_state_t               r_state;
  logic                        r_init_meta;
  logic                        r_init_sync;
  logic                        r_busy;
  logic                        r_en;
  logic [P_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                  r_len;
  logic                        r_unloaded;
  logic [7:0]                  r_beat_cnt;
  logic                        r_beats_done;

  logic                         w_en;
  logic                         w_ready;
  logic                         w_accept;
  logic                         w_final_beat;
  logic [P_USER_DATA_WIDTH-1:0] w_user_data;
  logic                         w_user_valid;
  logic                         w_user_last;
  logic                         w_word_last;
  logic [P_AXI_ADDR_WIDTH:0]    w_next_sum;
  logic [P_AXI_ADDR_WIDTH-1:0]  w_next_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_init_meta <= 1'b0;
      r_init_sync <= 1'b0;
    end else begin
      r_init_meta <= i_ddr_init;
      r_init_sync <= r_init_meta;
    end
  end

  // One extra bit so a ring ending at the top of the address space cannot overflow.
  assign w_next_sum   = {1'b0, r_addr} + (P_AXI_ADDR_WIDTH + 1)'(P_RD_LENGTH);
  assign w_next_addr  = (w_next_sum >= {1'b0, i_user_faddr}) ? i_user_baddr
                                                             : w_next_sum[P_AXI_ADDR_WIDTH-1:0];
  assign w_en         = (r_state == ST_DATA) && !r_beats_done;
  assign w_final_beat = (r_beat_cnt == P_LEN_B);
  assign w_word_last  = w_user_valid && w_user_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_en         <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_unloaded   <= 1'b1;
      r_beat_cnt   <= '0;
      r_beats_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_user_req && r_init_sync) begin
            r_state <= ST_REQ;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
            r_len   <= P_LEN_B;
            if (r_unloaded) begin
              r_addr     <= i_user_baddr;
              r_unloaded <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (bus.i_a2u_ack) begin
            r_state      <= ST_DATA;
            r_en         <= 1'b0;
            r_beat_cnt   <= '0;
            r_beats_done <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_final_beat) r_beats_done <= 1'b1;
          end
          // Leave once the burst's final word has been presented.
          if (w_word_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_addr  <= w_next_addr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axi_rd_unpack #(
    .P_USER_DATA_WIDTH (P_USER_DATA_WIDTH),
    .P_AXI_DATA_WIDTH  (P_AXI_DATA_WIDTH)
  ) u_unpack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_en),
    .i_data      (bus.i_a2u_data),
    .i_valid     (bus.i_a2u_valid),
    .i_last_beat (w_final_beat),
    .o_ready     (w_ready),
    .o_accept    (w_accept),
    .o_data      (w_user_data),
    .o_valid     (w_user_valid),
    .o_last      (w_user_last)
  );

`ifdef AXI_RD_LAST_CHECK_EN
  logic r_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_accept && (bus.i_a2u_last != w_final_beat)) begin
      r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`else
  logic w_unused_last;
  assign w_unused_last = bus.i_a2u_last;
  assign o_err         = 1'b0;
`endif

  assign bus.o_user_busy  = r_busy;
  assign bus.o_user_data  = w_user_data;
  assign bus.o_user_valid = w_user_valid;
  assign bus.o_user_last  = w_user_last;
  assign bus.o_a2u_en     = r_en;
  assign bus.o_a2u_addr   = r_addr;
  assign bus.o_a2u_length = r_len;
  assign bus.o_a2u_ready  = w_ready;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_axi_rd_ctrl.sv
// Directed bench for axi_rd_ctrl: descriptor issue, unpacking order, address ring,
// valid gaps, ignored requests, last-beat check and mid-burst reset.
module tb_axi_rd_ctrl;
  import axi_rd_pkg::*;

  localparam int UW = 16;
  localparam int AW = 128;
  localparam int DW = 32;
  localparam int N_WORDS = 2048;
`ifdef AXI_RD_LAST_CHECK_EN
  localparam bit EXP_ERR_ON = 1'b1;
`else
  localparam bit EXP_ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ddr_init;
  logic [DW-1:0] baddr;
  logic [DW-1:0] faddr;
  logic          err;
  axi_rd_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [UW-1:0] exp_q[$];

  always #5 clk = ~clk;

  axi_rd_ctrl_if #(.P_USER_DATA_WIDTH(UW), .P_AXI_DATA_WIDTH(AW), .P_AXI_ADDR_WIDTH(DW)) bus ();

  axi_rd_ctrl #(
    .P_RD_LENGTH(4096), .P_USER_DATA_WIDTH(UW), .P_AXI_DATA_WIDTH(AW), .P_AXI_ADDR_WIDTH(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ddr_init(ddr_init),
    .i_user_baddr(baddr), .i_user_faddr(faddr),
    .bus(bus), .o_err(err), .o_dbg_state(dbg_state)
  );

  function automatic logic [AW-1:0] make_beat(input int k);
    logic [AW-1:0] b;
    for (int i = 0; i < 8; i++) b[i*UW +: UW] = UW'(k*8 + i);
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    total++;
    if (bus.o_a2u_en !== 1'b0 || bus.o_user_busy !== 1'b0 || bus.o_user_valid !== 1'b0 ||
        bus.o_user_last !== 1'b0 || bus.o_user_data !== '0 || bus.o_a2u_addr !== '0 ||
        bus.o_a2u_length !== 8'd0 || bus.o_a2u_ready !== 1'b0 || err !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL %s_outputs got en=%b busy=%b v=%b l=%b d=%h a=%h len=%h rdy=%b err=%b st=%0d exp all 0",
               tag, bus.o_a2u_en, bus.o_user_busy, bus.o_user_valid, bus.o_user_last, bus.o_user_data,
               bus.o_a2u_addr, bus.o_a2u_length, bus.o_a2u_ready, err, dbg_state);
    end
  endtask

  // One full burst; gap_mode selects the i_a2u_valid pattern, abort_beat>=0 resets mid-burst.
  task automatic do_burst(input logic [DW-1:0] exp_addr, input int gap_mode, input int ack_delay,
                          input int bad_last_beat, input int abort_beat, input bit busy_reqs);
    int k = 0, words = 0, acc_cyc = -1, first_v = -1, last_v = -1;
    bit done = 0, finished = 0, en_seen = 0, vld;
    logic [UW-1:0] exp_w;
    @(negedge clk); bus.i_user_req = 1'b1;
    @(negedge clk); bus.i_user_req = 1'b0;
    total++;
    if (bus.o_a2u_en !== 1'b1 || bus.o_a2u_addr !== exp_addr || bus.o_a2u_length !== 8'd255 ||
        bus.o_user_busy !== 1'b1 || dbg_state !== ST_REQ) begin
      bad++;
      $display("FAIL desc got en=%b addr=%h len=%0d busy=%b st=%0d exp en=1 addr=%h len=255 busy=1 st=1",
               bus.o_a2u_en, bus.o_a2u_addr, bus.o_a2u_length, bus.o_user_busy, dbg_state, exp_addr);
    end
    for (int d = 0; d < ack_delay; d++) begin
      bus.i_user_req = busy_reqs && (d == 0);
      @(negedge clk);
      bus.i_user_req = 1'b0;
    end
    total++;
    if (bus.o_a2u_en !== 1'b1 || bus.o_a2u_addr !== exp_addr) begin
      bad++;
      $display("FAIL desc_hold got en=%b addr=%h exp en=1 addr=%h", bus.o_a2u_en, bus.o_a2u_addr, exp_addr);
    end
    bus.i_a2u_ack = 1'b1;
    @(negedge clk); bus.i_a2u_ack = 1'b0;
    total++;
    if (bus.o_a2u_en !== 1'b0 || dbg_state !== ST_DATA) begin
      bad++;
      $display("FAIL ack got en=%b st=%0d exp en=0 st=2", bus.o_a2u_en, dbg_state);
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (done) begin
        finished = 1;
        break;
      end
      if (bus.o_a2u_en) en_seen = 1;
      total++;
      if (bus.o_user_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL word_extra got data=%h exp no word", bus.o_user_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.o_user_data !== exp_w || bus.o_user_last !== (words == N_WORDS - 1)) begin
            bad++;
            $display("FAIL word[%0d] got data=%h last=%b exp data=%h last=%b",
                     words, bus.o_user_data, bus.o_user_last, exp_w, (words == N_WORDS - 1));
          end
        end
        words++;
        if (bus.o_user_last) done = 1;
      end else if (bus.o_user_last !== 1'b0) begin
        bad++;
        $display("FAIL stray_last got last=%b exp 0 at cycle %0d", bus.o_user_last, cyc);
      end
      if (abort_beat >= 0 && k == abort_beat) begin
        bus.i_a2u_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (gap_mode)
        1:       vld = (cyc % 3) != 1;
        2:       vld = (cyc % 13) < 5;
        default: vld = 1'b1;
      endcase
      bus.i_a2u_valid = vld && (k < 256);
      bus.i_a2u_data  = make_beat(k);
      bus.i_a2u_last  = (k == 255) || (k == bad_last_beat);
      bus.i_user_req  = busy_reqs && (cyc == 10);
      #1;
      if (bus.i_a2u_valid && bus.o_a2u_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        for (int i = 0; i < 8; i++) exp_q.push_back(UW'(k*8 + i));
        k++;
      end
      @(negedge clk);
    end
    bus.i_a2u_valid = 1'b0;
    bus.i_a2u_last  = 1'b0;
    bus.i_user_req  = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL burst_timeout got words=%0d exp %0d", words, N_WORDS);
      return;
    end
    total++;
    if (dbg_state !== ST_IDLE || bus.o_user_busy !== 1'b0 || exp_q.size() != 0 || words != N_WORDS || en_seen) begin
      bad++;
      $display("FAIL burst_end got st=%0d busy=%b left=%0d words=%0d en_seen=%b exp st=0 busy=0 left=0 words=%0d en_seen=0",
               dbg_state, bus.o_user_busy, exp_q.size(), words, en_seen, N_WORDS);
    end
    total++;
    if (first_v - acc_cyc != 2) begin
      bad++;
      $display("FAIL first_latency got %0d exp 2", first_v - acc_cyc);
    end
    if (gap_mode == 0) begin
      total++;
      if (last_v - first_v + 1 != N_WORDS) begin
        bad++;
        $display("FAIL gap_free got span=%0d exp %0d", last_v - first_v + 1, N_WORDS);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ddr_init = 1'b0; baddr = '0; faddr = '0;
    bus.i_user_req = 1'b0; bus.i_a2u_ack = 1'b0; bus.i_a2u_data = '0;
    bus.i_a2u_valid = 1'b0; bus.i_a2u_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    bus.i_a2u_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");
    bus.i_a2u_valid = 1'b0;
    baddr = 32'h0000_1000; faddr = 32'h0000_4000; ddr_init = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    do_burst(32'h0000_1000, 0, 0, -1, -1, 1'b0);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clean got %b exp 0", err);
    end
  endtask

  task automatic test_ring();
    do_burst(32'h0000_2000, 1, 3, -1, -1, 1'b1);
    do_burst(32'h0000_3000, 2, 1, -1, -1, 1'b0);
    do_burst(32'h0000_1000, 1, 0, -1, -1, 1'b1);
  endtask

  task automatic test_init_low();
    ddr_init = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_user_req = 1'b1;
    @(negedge clk); bus.i_user_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.o_a2u_en !== 1'b0 || bus.o_user_busy !== 1'b0 || dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL init_low got en=%b busy=%b st=%0d exp 0 0 0", bus.o_a2u_en, bus.o_user_busy, dbg_state);
      end
      @(negedge clk);
    end
    ddr_init = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_last_err();
    do_burst(32'h0000_2000, 0, 2, 100, -1, 1'b0);
    total++;
    if (err !== EXP_ERR_ON) begin
      bad++;
      $display("FAIL last_err got %b exp %b", err, EXP_ERR_ON);
    end
    repeat (5) @(negedge clk);
    total++;
    if (err !== EXP_ERR_ON) begin
      bad++;
      $display("FAIL last_err_sticky got %b exp %b", err, EXP_ERR_ON);
    end
  endtask

  task automatic test_reset_mid();
    do_burst(32'h0000_3000, 0, 0, -1, 50, 1'b0);
    repeat (4) @(negedge clk);
    check_all_zero("post_abort");
    do_burst(32'h0000_1000, 0, 1, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ring();
    test_init_low();
    test_last_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
